// File: rtl/seq_match_monitor_if.sv
// Handshake inputs and status outputs for the multi-channel sequence monitor.
// master drives the observed protocol signals; slave is the monitor side.
interface seq_match_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH-1:0]       ready;
  logic [NUM_CH-1:0]       triggered;
  logic [NUM_CH-1:0]       matched;
  logic [NUM_CH-1:0]       fail;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH*CNT_W-1:0] match_cnt;

  modport master (
    output req, ack, valid, ready,
    input  triggered, matched, fail, overflow, match_cnt
  );

  modport slave (
    input  req, ack, valid, ready,
    output triggered, matched, fail, overflow, match_cnt
  );
endinterface

// File: rtl/seq_match_monitor.sv
// Per-channel detector for rose(req) ##[1:MAX_GAP] ack ##1 valid with overlapping attempt slots.
// Pulses (triggered/fail/overflow) appear one cycle after the deciding input; matched is sticky until ready.
module seq_match_monitor #(
  parameter int NUM_CH       = 4,
  parameter int MAX_GAP      = 4,
  parameter int MAX_ATTEMPTS = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  seq_match_monitor_if.slave mon
);

  localparam int GAP_W  = $clog2(MAX_GAP + 1);
  localparam int SLOT_W = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_VALID} slot_st_e;

  slot_st_e            st_q  [NUM_CH][MAX_ATTEMPTS];
  slot_st_e            st_d  [NUM_CH][MAX_ATTEMPTS];
  logic [GAP_W-1:0]    gap_q [NUM_CH][MAX_ATTEMPTS];
  logic [GAP_W-1:0]    gap_d [NUM_CH][MAX_ATTEMPTS];

  logic [NUM_CH-1:0]   req_q;
  logic [NUM_CH-1:0]   rose;
  logic [NUM_CH-1:0]   trig_q, trig_d;
  logic [NUM_CH-1:0]   fail_q, fail_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [NUM_CH-1:0]   matched_q, matched_d;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_CH-1:0]   grant_vld;
  logic [NUM_CH-1:0]   alloc_vld;
  logic [SLOT_W-1:0]   grant_sel [NUM_CH];
  logic [SLOT_W-1:0]   alloc_sel [NUM_CH];
  logic [GAP_W-1:0]    best_gap  [NUM_CH];

  assign rose = mon.req & ~req_q;

  // Ack goes to the longest-waiting slot; a new attempt takes the lowest idle slot.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      grant_vld[c] = 1'b0;
      grant_sel[c] = '0;
      best_gap[c]  = '0;
      alloc_vld[c] = 1'b0;
      alloc_sel[c] = '0;
      for (int s = MAX_ATTEMPTS - 1; s >= 0; s--) begin
        if (st_q[c][s] == IDLE) begin
          alloc_vld[c] = 1'b1;
          alloc_sel[c] = SLOT_W'(s);
        end
      end
      for (int s = 0; s < MAX_ATTEMPTS; s++) begin
        if (st_q[c][s] == WAIT_ACK && (!grant_vld[c] || gap_q[c][s] > best_gap[c])) begin
          grant_vld[c] = 1'b1;
          grant_sel[c] = SLOT_W'(s);
          best_gap[c]  = gap_q[c][s];
        end
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    gap_d     = gap_q;
    trig_d    = '0;
    fail_d    = '0;
    ovf_d     = '0;
    matched_d = matched_q;
    cnt_d     = cnt_q;

    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < MAX_ATTEMPTS; s++) begin
        case (st_q[c][s])
          WAIT_ACK: begin
            if (mon.ack[c] && grant_vld[c] && grant_sel[c] == SLOT_W'(s)) begin
              st_d[c][s] = WAIT_VALID;
            end else if (gap_q[c][s] == GAP_W'(MAX_GAP)) begin
              st_d[c][s] = IDLE;
              fail_d[c]  = 1'b1;
            end else begin
              gap_d[c][s] = gap_q[c][s] + GAP_W'(1);
            end
          end
          WAIT_VALID: begin
            st_d[c][s] = IDLE;
            if (mon.valid[c]) trig_d[c] = 1'b1;
            else              fail_d[c] = 1'b1;
          end
          default: ;
        endcase
      end

      // Allocation looks at this cycle's state, so a slot freed now is reusable next cycle.
      if (rose[c]) begin
        if (alloc_vld[c]) begin
          st_d[c][alloc_sel[c]]  = WAIT_ACK;
          gap_d[c][alloc_sel[c]] = GAP_W'(1);
        end else begin
          ovf_d[c] = 1'b1;
        end
      end

      // A ready that coincides with the triggered pulse does not consume the fresh match.
      matched_d[c] = trig_d[c] | trig_q[c] | (matched_q[c] & ~mon.ready[c]);

      if (trig_d[c] && cnt_q[c*CNT_W +: CNT_W] != CNT_MAX) begin
        cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end

    if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < MAX_ATTEMPTS; s++) begin
          st_d[c][s] = IDLE;
        end
      end
      trig_d    = '0;
      fail_d    = '0;
      ovf_d     = '0;
      matched_d = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < MAX_ATTEMPTS; s++) begin
          st_q[c][s]  <= IDLE;
          gap_q[c][s] <= '0;
        end
      end
      req_q     <= '0;
      trig_q    <= '0;
      fail_q    <= '0;
      ovf_q     <= '0;
      matched_q <= '0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      gap_q     <= gap_d;
      req_q     <= mon.req;
      trig_q    <= trig_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
      matched_q <= matched_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mon.triggered = trig_q;
  assign mon.matched   = matched_q;
  assign mon.fail      = fail_q;
  assign mon.overflow  = ovf_q;
  assign mon.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Random and directed stimulus for seq_match_monitor, checked every cycle against an attempt-queue model.
module tb_seq_match_monitor;

  localparam int NCH  = 4;
  localparam int MG   = 4;
  localparam int MA   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [NCH-1:0] C0 = 1;
  localparam logic [NCH-1:0] Z  = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  bit   chk_on = 1'b0;
  int   nvec = 0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seq_match_monitor_if #(.NUM_CH(NCH), .CNT_W(CW)) mif ();

  seq_match_monitor #(
    .NUM_CH(NCH), .MAX_GAP(MG), .MAX_ATTEMPTS(MA), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .mon   (mif)
  );

  // Model: each channel holds a queue of rose cycles still waiting for ack
  // (oldest first) plus a flag for the attempt that must see valid this cycle.
  int             q [NCH][$];
  bit             vph [NCH];
  int             e_cnt [NCH];
  logic [NCH-1:0] rq, e_trig, e_fail, e_ovf, e_match;
  int             tcur = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*CW-1:0] cnt_flat();
    logic [NCH*CW-1:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++) f[c*CW +: CW] = CW'(e_cnt[c]);
    return f;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      vph[c]   = 1'b0;
      e_cnt[c] = 0;
    end
    rq = '0; e_trig = '0; e_fail = '0; e_ovf = '0; e_match = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit t_n, f_n, o_n, nv;
      int busy;
      t_n = 1'b0; f_n = 1'b0; o_n = 1'b0; nv = 1'b0;
      busy = q[c].size() + int'(vph[c]);
      if (clear) begin
        q[c].delete();
        vph[c]     = 1'b0;
        e_match[c] = 1'b0;
        e_cnt[c]   = 0;
      end else begin
        if (vph[c]) begin
          if (mif.valid[c]) t_n = 1'b1;
          else              f_n = 1'b1;
        end
        if (mif.ack[c] && q[c].size() > 0) begin
          void'(q[c].pop_front());
          nv = 1'b1;
        end
        while (q[c].size() > 0 && tcur - q[c][0] >= MG) begin
          void'(q[c].pop_front());
          f_n = 1'b1;
        end
        vph[c] = nv;
        if (mif.req[c] && !rq[c]) begin
          if (busy < MA) q[c].push_back(tcur);
          else           o_n = 1'b1;
        end
        e_match[c] = t_n | e_trig[c] | (e_match[c] & ~mif.ready[c]);
        if (t_n && e_cnt[c] < CMAX) e_cnt[c]++;
      end
      e_trig[c] = t_n;
      e_fail[c] = f_n;
      e_ovf[c]  = o_n;
    end
    rq = mif.req;
    tcur++;
  endtask

  task automatic cyc(input logic [NCH-1:0] r, a, v, rd, input logic clr);
    mif.req = r; mif.ack = a; mif.valid = v; mif.ready = rd; clear = clr;
    @(posedge clk);
    #1;
    model_step();
    nvec++;
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("triggered", 32'(mif.triggered), 32'(e_trig));
      chk("matched",   32'(mif.matched),   32'(e_match));
      chk("fail",      32'(mif.fail),      32'(e_fail));
      chk("overflow",  32'(mif.overflow),  32'(e_ovf));
      chk("match_cnt", 32'(mif.match_cnt), 32'(cnt_flat()));
    end
  end

  initial begin
    logic [NCH-1:0] r, a, v, rd;
    rst_n = 1'b0; clear = 1'b0;
    mif.req = '0; mif.ack = '0; mif.valid = '0; mif.ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_triggered", 32'(mif.triggered), 0);
    chk("rst_matched",   32'(mif.matched),   0);
    chk("rst_cnt",       32'(mif.match_cnt), 0);
    chk("rst_fail",      32'(mif.fail | mif.overflow), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (2) cyc(Z, Z, Z, Z, 1'b0);

    // Single completion with minimum gap.
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(Z, C0, Z, Z, 1'b0);
    cyc(Z, Z, C0, Z, 1'b0);
    chk("basic_trig",    32'(mif.triggered), 1);
    chk("basic_matched", 32'(mif.matched), 1);
    chk("basic_cnt",     32'(mif.match_cnt[CW-1:0]), 1);
    chk("basic_fail",    32'(mif.fail), 0);
    cyc(Z, Z, Z, Z, 1'b0);
    chk("basic_trig_once", 32'(mif.triggered), 0);
    chk("basic_held",      32'(mif.matched), 1);
    cyc(Z, Z, Z, C0, 1'b0);
    chk("ready_consume", 32'(mif.matched), 0);

    // Timeout after MAX_GAP cycles without ack.
    cyc(C0, Z, Z, Z, 1'b0);
    repeat (3) cyc(Z, Z, Z, Z, 1'b0);
    chk("timeout_early", 32'(mif.fail), 0);
    cyc(Z, Z, Z, Z, 1'b0);
    chk("timeout_fail", 32'(mif.fail), 1);
    chk("timeout_trig", 32'(mif.triggered), 0);
    cyc(Z, Z, Z, Z, 1'b0);
    chk("timeout_once", 32'(mif.fail), 0);

    // Two overlapping attempts, a third rose overflows, second completes at gap 4.
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(Z, Z, Z, Z, 1'b0);
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(Z, C0, Z, Z, 1'b0);
    cyc(C0, Z, C0, Z, 1'b0);
    chk("ovl_overflow", 32'(mif.overflow), 1);
    chk("ovl_trig1",    32'(mif.triggered), 1);
    cyc(Z, Z, Z, Z, 1'b0);
    chk("ovl_overflow_once", 32'(mif.overflow), 0);
    cyc(Z, C0, Z, Z, 1'b0);
    chk("ovl_no_early", 32'(mif.triggered | mif.fail), 0);
    cyc(Z, Z, C0, Z, 1'b0);
    chk("ovl_trig2", 32'(mif.triggered), 1);
    chk("ovl_cnt",   32'(mif.match_cnt[CW-1:0]), 3);

    // Ready during the triggered pulse: the set wins.
    cyc(Z, Z, Z, C0, 1'b0);
    chk("setwins_matched", 32'(mif.matched), 1);
    cyc(Z, Z, Z, C0, 1'b0);
    chk("setwins_consume", 32'(mif.matched), 0);

    // Clear during an attempt, then req held high across a clear.
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(Z, C0, Z, Z, 1'b0);
    cyc(Z, Z, C0, Z, 1'b1);
    chk("clear_trig", 32'(mif.triggered | mif.fail), 0);
    chk("clear_cnt",  32'(mif.match_cnt), 0);
    cyc(Z, Z, Z, Z, 1'b0);
    chk("clear_after", 32'(mif.triggered | mif.fail), 0);
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(C0, Z, Z, Z, 1'b1);
    cyc(C0, C0, Z, Z, 1'b0);
    cyc(Z, Z, C0, Z, 1'b0);
    chk("held_req_norose", 32'(mif.triggered | mif.fail), 0);

    // Counter saturation.
    for (int k = 1; k <= CMAX + 2; k++) begin
      cyc(C0, Z, Z, Z, 1'b0);
      cyc(Z, C0, Z, Z, 1'b0);
      cyc(Z, Z, C0, Z, 1'b0);
      chk("sat_cnt", 32'(mif.match_cnt[CW-1:0]), (k < CMAX) ? k : CMAX);
    end

    // Async reset while an attempt waits for valid.
    cyc(C0, Z, Z, Z, 1'b0);
    cyc(Z, C0, Z, Z, 1'b0);
    mif.valid = C0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'(mif.triggered | mif.fail | mif.overflow | mif.matched), 0);
    chk("arst_cnt",     32'(mif.match_cnt), 0);
    model_reset();
    mif.req = '0; mif.ack = '0; mif.valid = '0; mif.ready = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(Z, Z, C0, Z, 1'b0);
    chk("arst_no_fail", 32'(mif.fail | mif.triggered), 0);

    // Random traffic on all channels.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        r[c]  = ($urandom_range(0, 2) == 0);
        a[c]  = ($urandom_range(0, 2) == 0);
        v[c]  = ($urandom_range(0, 1) == 0);
        rd[c] = ($urandom_range(0, 3) == 0);
      end
      cyc(r, a, v, rd, ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
